// File: rtl/adc_scheduler_if.sv
// rtl/adc_scheduler_if.sv - ADC pins, request and result signals of the ADC scheduler
interface adc_scheduler_if;
   logic [7:0]  ch_mask;
   logic        req_valid;
   logic [2:0]  req_ch;
   logic        req_ready;
   logic        adc_cs_n;
   logic        adc_sck;
   logic        adc_din;
   logic        adc_dout;
   logic        data_valid;
   logic [2:0]  data_ch;
   logic [11:0] data_out;
   logic        busy;

   // Scheduler side
   modport slave (
      input  ch_mask, req_valid, req_ch, adc_dout,
      output req_ready, adc_cs_n, adc_sck, adc_din, data_valid, data_ch, data_out, busy
   );

   // Pin / consumer side
   modport master (
      output ch_mask, req_valid, req_ch, adc_dout,
      input  req_ready, adc_cs_n, adc_sck, adc_din, data_valid, data_ch, data_out, busy
   );
endinterface

// File: rtl/adc_scheduler.sv
// rtl/adc_scheduler.sv - round-robin / priority scheduler for an 8-channel address-pipelined SPI ADC
module adc_scheduler #(
   parameter int DIV_HALF = 8
) (
   input  logic           clk_50M,
   input  logic           rst,
   adc_scheduler_if.slave bus
);

   localparam int DW = (DIV_HALF > 1) ? $clog2(DIV_HALF) : 1;

   typedef enum logic [1:0] {IDLE, FRAME, GAP} state_t;

   state_t         state_q, state_d;
   logic [DW-1:0]  div_q, div_d;
   logic [5:0]     half_q, half_d;
   logic [2:0]     rr_ptr_q, rr_ptr_d;
   logic [2:0]     sent_ch_q, sent_ch_d;
   logic           flush_q, flush_d;
   logic [2:0]     pend_ch_q, pend_ch_d;
   logic           pend_v_q, pend_v_d;
   logic           req_latched_q, req_latched_d;
   logic [2:0]     req_ch_q, req_ch_d;
   logic [11:0]    shift_q, shift_d;
   logic           cs_n_q, cs_n_d;
   logic           sck_q, sck_d;
   logic           din_q, din_d;
   logic           dv_q, dv_d;
   logic [2:0]     data_ch_q, data_ch_d;
   logic [11:0]    data_out_q, data_out_d;

   logic           rr_found;
   logic [2:0]     rr_next;
   logic [2:0]     cand;
   logic           boundary;
   logic [5:0]     h;
   logic           take_req;

   // First enabled channel strictly after rr_ptr, wrapping 7->0 (rr_ptr itself is tried last)
   always_comb begin
      rr_found = 1'b0;
      rr_next  = rr_ptr_q;
      cand     = '0;
      for (int i = 1; i <= 8; i++) begin
         cand = rr_ptr_q + 3'(i);
         if (!rr_found && bus.ch_mask[cand]) begin
            rr_found = 1'b1;
            rr_next  = cand;
         end
      end
   end

   assign boundary = (div_q == DW'(DIV_HALF - 1));
   assign h        = half_q + 6'd1;

   // Next-state: slot decision in IDLE, SCLK/DIN/DOUT sequencing in FRAME, CS-high spacing in GAP
   always_comb begin
      state_d    = state_q;
      div_d      = div_q;
      half_d     = half_q;
      rr_ptr_d   = rr_ptr_q;
      sent_ch_d  = sent_ch_q;
      flush_d    = flush_q;
      pend_ch_d  = pend_ch_q;
      pend_v_d   = pend_v_q;
      shift_d    = shift_q;
      cs_n_d     = cs_n_q;
      sck_d      = sck_q;
      din_d      = din_q;
      dv_d       = 1'b0;
      data_ch_d  = data_ch_q;
      data_out_d = data_out_q;
      take_req   = 1'b0;

      case (state_q)
         IDLE: begin
            div_d  = '0;
            half_d = '0;
            if (req_latched_q) begin
               take_req  = 1'b1;
               sent_ch_d = req_ch_q;
               flush_d   = 1'b0;
               cs_n_d    = 1'b0;
               state_d   = FRAME;
            end else if (rr_found) begin
               sent_ch_d = rr_next;
               rr_ptr_d  = rr_next;
               flush_d   = 1'b0;
               cs_n_d    = 1'b0;
               state_d   = FRAME;
            end else if (pend_v_q) begin
               // Nothing to convert but a result is still inside the ADC: fetch it
               sent_ch_d = 3'd0;
               flush_d   = 1'b1;
               cs_n_d    = 1'b0;
               state_d   = FRAME;
            end
         end
         FRAME: begin
            div_d = boundary ? '0 : div_q + DW'(1);
            if (boundary) begin
               half_d = h;
               if (h == 6'd33) begin
                  cs_n_d  = 1'b1;
                  din_d   = 1'b0;
                  state_d = GAP;
                  if (pend_v_q) begin
                     dv_d       = 1'b1;
                     data_ch_d  = pend_ch_q;
                     data_out_d = shift_q;
                  end
                  pend_ch_d = sent_ch_q;
                  pend_v_d  = ~flush_q;
               end else if (h[0]) begin
                  // Falling SCLK of bit k = half_q/2; address goes out on bits 2..4
                  sck_d = 1'b0;
                  case (half_q[5:1])
                     5'd2:    din_d = sent_ch_q[2];
                     5'd3:    din_d = sent_ch_q[1];
                     5'd4:    din_d = sent_ch_q[0];
                     default: din_d = 1'b0;
                  endcase
               end else begin
                  // Rising SCLK; bits 4..15 carry the 12-bit result MSB first
                  sck_d = 1'b1;
                  if (h >= 6'd10) begin
                     shift_d = {shift_q[10:0], bus.adc_dout};
                  end
               end
            end
         end
         GAP: begin
            div_d = boundary ? '0 : div_q + DW'(1);
            if (boundary) begin
               half_d = h;
               if (h == 6'd35) begin
                  state_d = IDLE;
               end
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // A request latch is consumed only by the decision; a new one can latch once it is free
   always_comb begin
      req_latched_d = req_latched_q;
      req_ch_d      = req_ch_q;
      if (take_req) begin
         req_latched_d = 1'b0;
      end else if (bus.req_valid && !req_latched_q) begin
         req_latched_d = 1'b1;
         req_ch_d      = bus.req_ch;
      end
   end

   // State and output registers; reset abandons any partial frame and latched request
   always_ff @(posedge clk_50M or posedge rst) begin
      if (rst) begin
         state_q       <= IDLE;
         div_q         <= '0;
         half_q        <= '0;
         rr_ptr_q      <= 3'd7;
         sent_ch_q     <= '0;
         flush_q       <= 1'b0;
         pend_ch_q     <= '0;
         pend_v_q      <= 1'b0;
         req_latched_q <= 1'b0;
         req_ch_q      <= '0;
         shift_q       <= '0;
         cs_n_q        <= 1'b1;
         sck_q         <= 1'b1;
         din_q         <= 1'b0;
         dv_q          <= 1'b0;
         data_ch_q     <= '0;
         data_out_q    <= '0;
      end else begin
         state_q       <= state_d;
         div_q         <= div_d;
         half_q        <= half_d;
         rr_ptr_q      <= rr_ptr_d;
         sent_ch_q     <= sent_ch_d;
         flush_q       <= flush_d;
         pend_ch_q     <= pend_ch_d;
         pend_v_q      <= pend_v_d;
         req_latched_q <= req_latched_d;
         req_ch_q      <= req_ch_d;
         shift_q       <= shift_d;
         cs_n_q        <= cs_n_d;
         sck_q         <= sck_d;
         din_q         <= din_d;
         dv_q          <= dv_d;
         data_ch_q     <= data_ch_d;
         data_out_q    <= data_out_d;
      end
   end

   assign bus.req_ready  = ~req_latched_q;
   assign bus.adc_cs_n   = cs_n_q;
   assign bus.adc_sck    = sck_q;
   assign bus.adc_din    = din_q;
   assign bus.data_valid = dv_q;
   assign bus.data_ch    = data_ch_q;
   assign bus.data_out   = data_out_q;
   assign bus.busy       = (state_q != IDLE);

endmodule

// File: tb/tb_adc_scheduler.sv
// tb/tb_adc_scheduler.sv - self-checking bench for adc_scheduler with an ADC pin model and scoreboard
module tb_adc_scheduler;
   localparam int D = 8;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #10 clk = ~clk;

   adc_scheduler_if bus_if ();
   adc_scheduler #(.DIV_HALF(D)) dut (.clk_50M(clk), .rst(rst), .bus(bus_if));

   typedef struct packed { logic [2:0] ch; logic [11:0] data; } res_t;
   typedef struct packed { logic [7:0] mask; logic [2:0] a0, a1, a2, a3; } rr_vec_t;

   int checks = 0;
   int failures = 0;
   logic [2:0] exp_addr_q[$];
   res_t       exp_res_q[$];
   int frame_cnt = 0;
   int acc_cnt = 0;
   int ncyc = 0;
   int t0 = 0, last_t0 = 0, prev_t0 = 0;
   rr_vec_t tbl[5];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", name, act, req);
      end
   endtask

   task automatic push_frame(input logic [2:0] a);
      exp_addr_q.push_back(a);
   endtask

   task automatic push_res(input logic [2:0] c);
      res_t r;
      r.ch = c;
      r.data = 12'hA00 + {9'd0, c};
      exp_res_q.push_back(r);
   endtask

   // ADC pin model: decodes the address, returns 0xA00 + previous address, checks frame timing
   initial begin
      logic pcs, psck, in_frame, din_bad;
      logic [2:0] addr;
      logic [11:0] res;
      int nf, nr;
      pcs = 1'b1; psck = 1'b1; in_frame = 1'b0; din_bad = 1'b0;
      addr = '0; res = '0; nf = 0; nr = 0;
      bus_if.adc_dout = 1'b0;
      forever begin
         @(negedge clk);
         ncyc++;
         if (rst) begin
            pcs = 1'b1; psck = 1'b1; in_frame = 1'b0; frame_cnt = 0;
            bus_if.adc_dout = 1'b0;
         end else begin
            if (pcs && !bus_if.adc_cs_n) begin
               in_frame = 1'b1; t0 = ncyc; prev_t0 = last_t0; last_t0 = ncyc;
               nf = 0; nr = 0; addr = '0; din_bad = 1'b0;
               frame_cnt++;
            end else if (in_frame) begin
               if (psck && !bus_if.adc_sck) begin
                  if (nf == 0) chk("first_sck_fall_cycle", ncyc - t0, D);
                  bus_if.adc_dout = (nf >= 4) ? res[15 - nf] : 1'b0;
                  nf++;
               end
               if (!psck && bus_if.adc_sck) begin
                  if (nr >= 2 && nr <= 4) addr = {addr[1:0], bus_if.adc_din};
                  else if (bus_if.adc_din) din_bad = 1'b1;
                  nr++;
               end
               if (!pcs && bus_if.adc_cs_n) begin
                  chk("cs_low_cycles", ncyc - t0, 33 * D);
                  chk("sck_rises", nr, 16);
                  chk("din_idle_zero", din_bad, 0);
                  if (exp_addr_q.size() == 0) chk("extra_frame", 1, 0);
                  else chk("frame_addr", addr, exp_addr_q.pop_front());
                  res = 12'hA00 + {9'd0, addr};
                  in_frame = 1'b0;
               end
            end
            pcs = bus_if.adc_cs_n;
            psck = bus_if.adc_sck;
         end
      end
   end

   // Result scoreboard and request-handshake monitor
   initial begin
      logic prev_dv, prev_acc;
      res_t e;
      prev_dv = 1'b0; prev_acc = 1'b0;
      forever begin
         @(negedge clk);
         if (rst) begin
            prev_dv = 1'b0; prev_acc = 1'b0;
         end else begin
            if (bus_if.data_valid) begin
               chk("data_valid_width", prev_dv, 0);
               if (exp_res_q.size() == 0) chk("extra_result", 1, 0);
               else begin
                  e = exp_res_q.pop_front();
                  chk("data_ch", bus_if.data_ch, e.ch);
                  chk("data_out", bus_if.data_out, e.data);
               end
            end
            if (prev_acc) chk("req_ready_drop", bus_if.req_ready, 0);
            prev_dv = bus_if.data_valid;
            prev_acc = bus_if.req_valid && bus_if.req_ready;
            if (prev_acc) acc_cnt++;
         end
      end
   end

   task automatic reset_dut();
      @(posedge clk); #2;
      rst = 1'b1;
      exp_addr_q.delete();
      exp_res_q.delete();
      repeat (3) @(posedge clk);
      #2 rst = 1'b0;
   endtask

   task automatic wait_frames(input int n);
      int t;
      t = 0;
      while (frame_cnt < n && t < 2000) begin
         @(posedge clk); #2;
         t++;
      end
      chk("frame_wait_timeout", frame_cnt >= n, 1);
   endtask

   task automatic finish_run(input int n);
      wait_frames(n);
      repeat (400) @(posedge clk);
      #2;
      chk("end_busy", bus_if.busy, 0);
      chk("end_cs_n", bus_if.adc_cs_n, 1);
      chk("end_frame_count", frame_cnt, n);
      chk("end_addr_queue", exp_addr_q.size(), 0);
      chk("end_result_queue", exp_res_q.size(), 0);
   endtask

   initial begin
      int acc_base;
      tbl[0] = '{mask: 8'h05, a0: 3'd0, a1: 3'd2, a2: 3'd0, a3: 3'd2};
      tbl[1] = '{mask: 8'h80, a0: 3'd7, a1: 3'd7, a2: 3'd7, a3: 3'd7};
      tbl[2] = '{mask: 8'h12, a0: 3'd1, a1: 3'd4, a2: 3'd1, a3: 3'd4};
      tbl[3] = '{mask: 8'hFF, a0: 3'd0, a1: 3'd1, a2: 3'd2, a3: 3'd3};
      tbl[4] = '{mask: 8'h48, a0: 3'd3, a1: 3'd6, a2: 3'd3, a3: 3'd6};
      bus_if.ch_mask = 8'h00;
      bus_if.req_valid = 1'b0;
      bus_if.req_ch = 3'd0;

      // Reset values
      repeat (2) @(posedge clk);
      #2;
      chk("rst_cs_n", bus_if.adc_cs_n, 1);
      chk("rst_sck", bus_if.adc_sck, 1);
      chk("rst_din", bus_if.adc_din, 0);
      chk("rst_data_valid", bus_if.data_valid, 0);
      chk("rst_data_ch", bus_if.data_ch, 0);
      chk("rst_data_out", bus_if.data_out, 0);
      chk("rst_busy", bus_if.busy, 0);
      chk("rst_req_ready", bus_if.req_ready, 1);
      rst = 1'b0;

      // Round-robin vectors: four frames, then mask cleared so a flush frame drains the pipeline
      for (int i = 0; i < 5; i++) begin
         reset_dut();
         bus_if.ch_mask = tbl[i].mask;
         push_frame(tbl[i].a0); push_frame(tbl[i].a1);
         push_frame(tbl[i].a2); push_frame(tbl[i].a3); push_frame(3'd0);
         push_res(tbl[i].a0); push_res(tbl[i].a1);
         push_res(tbl[i].a2); push_res(tbl[i].a3);
         wait_frames(2);
         chk("frame_period", last_t0 - prev_t0, 35 * D + 1);
         wait_frames(4);
         bus_if.ch_mask = 8'h00;
         finish_run(5);
      end

      // Single request from IDLE with an empty mask
      reset_dut();
      push_frame(3'd5); push_frame(3'd0);
      push_res(3'd5);
      @(posedge clk); #2;
      bus_if.req_ch = 3'd5; bus_if.req_valid = 1'b1;
      @(posedge clk); #2;
      bus_if.req_valid = 1'b0;
      chk("req5_ready_low", bus_if.req_ready, 0);
      finish_run(2);

      // Priority request pre-empts round-robin while the ch1 frame is active
      reset_dut();
      bus_if.ch_mask = 8'hFF;
      push_frame(3'd0); push_frame(3'd1); push_frame(3'd6); push_frame(3'd2); push_frame(3'd0);
      push_res(3'd0); push_res(3'd1); push_res(3'd6); push_res(3'd2);
      wait_frames(2);
      bus_if.req_ch = 3'd6; bus_if.req_valid = 1'b1;
      @(posedge clk); #2;
      bus_if.req_valid = 1'b0;
      chk("req6_ready_low", bus_if.req_ready, 0);
      repeat (100) @(posedge clk);
      #2;
      chk("req6_ready_held", bus_if.req_ready, 0);
      wait_frames(3);
      chk("req6_ready_free", bus_if.req_ready, 1);
      wait_frames(4);
      bus_if.ch_mask = 8'h00;
      finish_run(5);

      // req_valid held high: one latch per decision
      reset_dut();
      push_frame(3'd3); push_frame(3'd3); push_frame(3'd3); push_frame(3'd3); push_frame(3'd0);
      push_res(3'd3); push_res(3'd3); push_res(3'd3); push_res(3'd3);
      acc_base = acc_cnt;
      bus_if.req_ch = 3'd3; bus_if.req_valid = 1'b1;
      wait_frames(3);
      bus_if.req_valid = 1'b0;
      finish_run(5);
      chk("held_req_latches", acc_cnt - acc_base, 4);

      // Reset asserted at bit 9 of a frame
      reset_dut();
      bus_if.ch_mask = 8'h01;
      wait_frames(1);
      repeat (155) @(posedge clk);
      #2;
      chk("midframe_cs_low", bus_if.adc_cs_n, 0);
      rst = 1'b1;
      #1;
      chk("abort_cs_n", bus_if.adc_cs_n, 1);
      chk("abort_sck", bus_if.adc_sck, 1);
      chk("abort_data_valid", bus_if.data_valid, 0);
      chk("abort_busy", bus_if.busy, 0);
      repeat (3) @(posedge clk);
      #2 rst = 1'b0;
      push_frame(3'd0); push_frame(3'd0); push_frame(3'd0);
      push_res(3'd0); push_res(3'd0);
      wait_frames(2);
      bus_if.ch_mask = 8'h00;
      finish_run(3);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/adc_scheduler.md
# adc_scheduler

Sequences the 8-channel SPI ADC (16-SCLK frames, 12-bit result, address-pipelined) from the 50 MHz system clock. It generates the ADC serial clock internally by dividing by 16 (3.125 MHz), so it does not depend on a separate scaled-clock block. Channels are scanned round-robin over an enable mask, and a single-shot priority request can pre-empt the next slot. It sits between the ADC pins and the line-sensor/control logic, which consumes tagged results.

## Interface
- DIV_HALF, 8: clk_50M cycles per SCLK half-period (8 gives 3.125 MHz).
- clk_50M  in  1  system clock; all logic on rising edge.
- rst  in  1  asynchronous, active-high reset.
- ch_mask  in  8  round-robin enable, bit n = channel n.
- req_valid  in  1  priority conversion request.
- req_ch  in  3  channel for the priority request.
- req_ready  out  1  request can be latched.
- adc_cs_n  out  1  ADC chip select, active low.
- adc_sck  out  1  ADC serial clock; idles high.
- adc_din  out  1  address bits to the ADC.
- adc_dout  in  1  serial data from the ADC.
- data_valid  out  1  one-cycle pulse when a result is ready.
- data_ch  out  3  channel the result belongs to.
- data_out  out  12  conversion result.
- busy  out  1  high whenever the FSM is not in IDLE.

## Operation
- FSM states: IDLE -> FRAME -> GAP -> IDLE (decision point) or FRAME.
- Decision, evaluated in IDLE using state registered before the edge:
  - A latched request takes priority: send req_ch, clear the latch.
  - Otherwise round-robin: the first enabled channel after rr_ptr, wrapping 7->0; rr_ptr updates to it. Requests do not move rr_ptr.
  - Otherwise, if a conversion is outstanding (pend_v=1): flush frame sending address 0, marked unwanted.
  - Otherwise stay in IDLE; adc_cs_n stays high.
- ch_mask is sampled only at the decision point.
- Pipeline: the result read in frame N belongs to the address sent in frame N-1. Tracking registers pend_ch/pend_v:
  - pend_v=0 after reset and after a flush frame; a frame started with pend_v=0 gives no data_valid.
  - At the end of each frame: pend_ch = sent address; pend_v = 1 for a real frame, 0 for a flush.
- Requests: req_ready = ~req_latched. A request latches when req_valid & req_ready; req_ch is captured then. Latching in the same cycle as a decision affects only the following decision.
- Frame bit k = 0..15:
  - adc_din = ADD2/ADD1/ADD0 of the sent address at k = 2, 3, 4; 0 at all other bits.
  - adc_dout is shifted in at rising edges k = 4..15, MSB first, giving data_out[11:0]. Bits k = 0..3 (leading zeros) are ignored.
- Result width is exactly 12 bits, with no extension or scaling.

## Timing
- Frame start is cycle 0, when adc_cs_n falls (registered).
- Bit k:
  - adc_sck falls at (2k+1)*DIV_HALF; adc_din updates on that same edge.
  - adc_sck rises at (2k+2)*DIV_HALF; adc_dout is sampled on the clk edge that drives adc_sck high.
- adc_cs_n rises at 33*DIV_HALF. data_valid, data_ch and data_out update on that edge; data_valid stays high for exactly one cycle. data_ch/data_out hold until the next result.
- GAP: adc_cs_n high for 2*DIV_HALF cycles, then the decision.
- Back-to-back frame period = 35*DIV_HALF + 1 cycles (281 at default).
- Result latency from request acceptance (no frame in flight) = 2 frames.
- Reset values: adc_cs_n=1, adc_sck=1, adc_din=0, data_valid=0, data_ch=0, data_out=0, busy=0, req_ready=1. Internal: rr_ptr=7, pend_v=0, request latch cleared.
- Reset asserted mid-frame: all outputs return to their reset values immediately (asynchronous). The partial frame, its result and any latched request are discarded.

## Test plan
- ch_mask=8'h05, no requests; ADC model returns 12'hA00+addr_of_previous_frame. Required: address sequence 0,2,0,2; first frame gives no data_valid; then results (ch0,A00), (ch2,A02) alternating, each valid one cycle wide; period 281 cycles.
- ch_mask=8'h00, request ch5 from IDLE. Required: frame sending 5, then flush frame sending 0, one data_valid with ch=5; then IDLE, busy=0, adc_cs_n=1.
- ch_mask=8'hFF, request ch6 accepted while the frame sending ch1 is active. Required: next frame sends 6, then round-robin resumes at 2; req_ready low from acceptance until the decision point.
- req_valid held high continuously. Required: only one latch per decision; req_ready deasserts the cycle after acceptance.
- Assert rst at bit k=9 of a frame. Required: adc_cs_n=1 and adc_sck=1 the same cycle, no data_valid; after release with ch_mask=8'h01, the first frame sends 0 and gives no valid output.
- Bit-level check with DIV_HALF=8 and address 3. Required: adc_din = 0,0,0,1,1,0... on falling edges; first adc_sck fall at cycle 8; adc_cs_n rises at cycle 264.
